// File: rtl/round_sequencer.sv
// Round sequencer for the reaction game: random LEDs-off delay, lit window,
// first-push arbitration, one-cycle result pulse, then wait for button release.
module round_sequencer #(
  parameter int                 CNT_W     = 24,
  parameter logic [CNT_W-1:0]   MIN_DELAY = CNT_W'(2000000),
  parameter int                 DLY_SHIFT = 14,
  parameter logic [CNT_W-1:0]   ON_TIME   = CNT_W'(8000000)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_l,
  input  logic       push_r,
  input  logic       game_over,
  output logic       leds_on,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    HOLD  = 3'd0,
    WAIT  = 3'd1,
    ON    = 3'd2,
    SCORE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       lfsr;
  logic [CNT_W-1:0] delay_load;
  logic             any_push;

  // Random part of the delay uses the lfsr value seen in the HOLD cycle.
  assign delay_load = MIN_DELAY + (CNT_W'(lfsr) << DLY_SHIFT);
  assign any_push   = push_l | push_r;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= HOLD;
      cnt     <= '0;
      lfsr    <= 8'h01;
      leds_on <= 1'b0;
      winrnd  <= 1'b0;
      right   <= 1'b0;
      tie     <= 1'b0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        HOLD: begin
          leds_on <= 1'b0;
          winrnd  <= 1'b0;
          right   <= 1'b0;
          tie     <= 1'b0;
          if (!any_push) begin
            if (game_over) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= delay_load;
            end
          end
        end
        WAIT: begin
          if (any_push) begin
            // Jump-the-light: scored with leds_on low so the scorer can tell.
            state   <= SCORE;
            winrnd  <= 1'b1;
            right   <= push_r & ~push_l;
            tie     <= push_r & push_l;
            leds_on <= 1'b0;
          end else if (cnt == '0) begin
            state   <= ON;
            cnt     <= ON_TIME;
            leds_on <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ON: begin
          if (any_push) begin
            state   <= SCORE;
            winrnd  <= 1'b1;
            right   <= push_r & ~push_l;
            tie     <= push_r & push_l;
            leds_on <= 1'b1;
          end else if (cnt == '0) begin
            state   <= HOLD;
            leds_on <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SCORE: begin
          state   <= HOLD;
          leds_on <= 1'b0;
          winrnd  <= 1'b0;
          right   <= 1'b0;
          tie     <= 1'b0;
        end
        DONE: begin
          leds_on <= 1'b0;
          winrnd  <= 1'b0;
          right   <= 1'b0;
          tie     <= 1'b0;
        end
        default: begin
          state   <= HOLD;
          leds_on <= 1'b0;
          winrnd  <= 1'b0;
          right   <= 1'b0;
          tie     <= 1'b0;
        end
      endcase
    end
  end

endmodule
